// File: rtl/mem_bridge.sv
// mem_bridge
//   Bridges an RV32I multicycle CPU's load/store requests onto a word-wide
//   memory port that uses a read/write strobe and a response handshake.
//   - Byte and halfword stores are lane-shifted: the data is replicated across
//     all lanes, and byte enables select the lanes that are written.
//   - Loads pick the addressed byte or halfword out of the returned word.
//     They are then sign- or zero-extended.
//   - Misaligned accesses, illegal funct3 codes, simultaneous read+write
//     requests and memory timeouts all complete with cpu_error set.
//   Every output is registered.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   cpu_read/write    : load / store request, sampled only while idle
//   cpu_funct3        : RV32I width code (lb/lh/lw/lbu/lhu, sb/sh/sw)
//   cpu_address       : byte address
//   cpu_wdata         : unshifted store data
//   cpu_rdata         : aligned and extended load data
//   cpu_resp          : one-cycle completion pulse
//   cpu_error         : error flag, valid together with cpu_resp
//   pmem_read/write   : memory strobes, held until response or timeout
//   pmem_address      : word address (bits [1:0] are zero)
//   pmem_wdata        : lane-shifted store data
//   pmem_byte_enable  : active-high lane enables
//   pmem_rdata/resp   : memory read data and response
module mem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_resp,
  output logic        cpu_error,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_byte_enable,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

  state_t      state, state_d;
  logic [7:0]  wait_cnt, wait_cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] cpu_rdata_d;
  logic        cpu_resp_d, cpu_error_d;
  logic        pmem_read_d, pmem_write_d;
  logic [31:0] pmem_address_d, pmem_wdata_d;
  logic [3:0]  pmem_byte_enable_d;
  logic [8:0]  waited;
  logic        timeout_hit;

  // Request is unusable: both strobes set, illegal width code, or misaligned.
  function automatic logic req_err(input logic rd, input logic wr,
                                   input logic [2:0] f3, input logic [1:0] off);
    logic bad_f3;
    logic misaligned;
    if (rd) begin
      bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end else begin
      bad_f3 = (f3[2] == 1'b1) || (f3[1:0] == 2'b11);
    end
    misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                 ((f3[1:0] == 2'b10) && (off != 2'b00));
    return (rd && wr) || bad_f3 || misaligned;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
    logic [31:0]        shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    shifted = rd >> {off, 3'b000};
    b       = shifted[7:0];
    h       = shifted[15:0];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'b0, shifted[7:0]};
      3'b101:  return {16'b0, shifted[15:0]};
      default: return rd;
    endcase
  endfunction

  // Abort once the strobe has been up for TIMEOUT cycles with no response.
  assign waited      = {1'b0, wait_cnt} + 9'd1;
  assign timeout_hit = (waited >= TIMEOUT_W);

  always_comb begin
    state_d            = state;
    wait_cnt_d         = wait_cnt;
    funct3_d           = funct3_q;
    offset_d           = offset_q;
    cpu_rdata_d        = cpu_rdata;
    cpu_resp_d         = 1'b0;
    cpu_error_d        = 1'b0;
    pmem_read_d        = pmem_read;
    pmem_write_d       = pmem_write;
    pmem_address_d     = pmem_address;
    pmem_wdata_d       = pmem_wdata;
    pmem_byte_enable_d = pmem_byte_enable;
    case (state)
      IDLE: begin
        if (cpu_read || cpu_write) begin
          if (req_err(cpu_read, cpu_write, cpu_funct3, cpu_address[1:0])) begin
            state_d     = DONE;
            cpu_resp_d  = 1'b1;
            cpu_error_d = 1'b1;
          end else begin
            pmem_address_d = {cpu_address[31:2], 2'b00};
            funct3_d       = cpu_funct3;
            offset_d       = cpu_address[1:0];
            wait_cnt_d     = 8'd0;
            if (cpu_read) begin
              state_d            = READ;
              pmem_read_d        = 1'b1;
              pmem_byte_enable_d = 4'b1111;
            end else begin
              state_d            = WRITE;
              pmem_write_d       = 1'b1;
              pmem_byte_enable_d = store_be(cpu_funct3, cpu_address[1:0]);
              pmem_wdata_d       = store_data(cpu_funct3, cpu_wdata);
            end
          end
        end
      end
      READ: begin
        if (pmem_resp) begin
          state_d     = DONE;
          pmem_read_d = 1'b0;
          cpu_rdata_d = load_extend(funct3_q, offset_q, pmem_rdata);
          cpu_resp_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d     = DONE;
          pmem_read_d = 1'b0;
          cpu_rdata_d = 32'd0;
          cpu_resp_d  = 1'b1;
          cpu_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + 8'd1;
        end
      end
      WRITE: begin
        if (pmem_resp) begin
          state_d      = DONE;
          pmem_write_d = 1'b0;
          cpu_resp_d   = 1'b1;
        end else if (timeout_hit) begin
          state_d      = DONE;
          pmem_write_d = 1'b0;
          cpu_rdata_d  = 32'd0;
          cpu_resp_d   = 1'b1;
          cpu_error_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      wait_cnt         <= 8'd0;
      funct3_q         <= 3'd0;
      offset_q         <= 2'd0;
      cpu_rdata        <= 32'd0;
      cpu_resp         <= 1'b0;
      cpu_error        <= 1'b0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_address     <= 32'd0;
      pmem_wdata       <= 32'd0;
      pmem_byte_enable <= 4'd0;
    end else begin
      state            <= state_d;
      wait_cnt         <= wait_cnt_d;
      funct3_q         <= funct3_d;
      offset_q         <= offset_d;
      cpu_rdata        <= cpu_rdata_d;
      cpu_resp         <= cpu_resp_d;
      cpu_error        <= cpu_error_d;
      pmem_read        <= pmem_read_d;
      pmem_write       <= pmem_write_d;
      pmem_address     <= pmem_address_d;
      pmem_wdata       <= pmem_wdata_d;
      pmem_byte_enable <= pmem_byte_enable_d;
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Testbench for mem_bridge: directed scenarios followed by randomized
// load/store traffic, compared against a byte-level reference model.
module tb_mem_bridge;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_read, cpu_write;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_address, cpu_wdata, cpu_rdata;
  logic        cpu_resp, cpu_error;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address, pmem_wdata, pmem_rdata;
  logic [3:0]  pmem_byte_enable;
  logic        pmem_resp;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_rdata;

  mem_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_funct3(cpu_funct3),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_resp(cpu_resp), .cpu_error(cpu_error),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int access_size(input logic [2:0] f3);
    logic [1:0] w;
    w = f3[1:0];
    if (w == 2'b00) return 1;
    if (w == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_err(input bit rd, input bit wr, input logic [2:0] f3,
                                   input logic [31:0] addr);
    if (rd && wr) return 1'b1;
    if (rd && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b1;
    if (wr && !(f3 inside {3'b000, 3'b001, 3'b010})) return 1'b1;
    return (int'(addr[1:0]) % access_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] word);
    int     size;
    longint v;
    size = access_size(f3);
    v = 0;
    for (int i = size - 1; i >= 0; i--) v = v * 256 + longint'(word[8*(off+i) +: 8]);
    if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size - 1)))
      v = v - (longint'(1) << (8*size));
    return 32'(v);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input int off);
    int size;
    int mask;
    size = access_size(f3);
    mask = (1 << size) - 1;
    return 4'(mask << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int          size;
    size = access_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % size) +: 8];
    return r;
  endfunction

  // One complete transaction; waits >= TIMEOUT means the memory never answers.
  task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int waits, input logic [31:0] mem_data);
    bit err;
    int off;
    int high;
    err = model_err(rd, wr, f3, addr);
    off = int'(addr[1:0]);
    @(negedge clk);
    cpu_read = rd; cpu_write = wr; cpu_funct3 = f3; cpu_address = addr; cpu_wdata = wd;
    @(negedge clk);
    cpu_read = 1'b0; cpu_write = 1'b0;
    if (err) begin
      check("err_resp", 32'(cpu_resp), 32'd1);
      check("err_flag", 32'(cpu_error), 32'd1);
      check("err_no_strobe", 32'({pmem_read, pmem_write}), 32'd0);
      check("err_rdata_kept", cpu_rdata, exp_rdata);
    end else begin
      check("strobe_read", 32'(pmem_read), 32'(rd));
      check("strobe_write", 32'(pmem_write), 32'(wr));
      check("address", pmem_address, {addr[31:2], 2'b00});
      check("byte_enable", 32'(pmem_byte_enable), rd ? 32'hF : 32'(model_be(f3, off)));
      if (wr) check("pmem_wdata", pmem_wdata, model_wdata(f3, wd));
      if (waits >= TIMEOUT) begin
        high = 1;
        while ((pmem_read || pmem_write) && high < TIMEOUT + 10) begin
          @(negedge clk);
          if (pmem_read || pmem_write) high++;
        end
        check("timeout_strobe_cycles", 32'(high), 32'(TIMEOUT));
        check("timeout_resp", 32'(cpu_resp), 32'd1);
        check("timeout_error", 32'(cpu_error), 32'd1);
        exp_rdata = 32'd0;
        check("timeout_rdata", cpu_rdata, exp_rdata);
      end else begin
        repeat (waits) begin
          @(negedge clk);
          check("strobe_hold", 32'(pmem_read || pmem_write), 32'd1);
          check("address_stable", pmem_address, {addr[31:2], 2'b00});
        end
        pmem_resp = 1'b1; pmem_rdata = mem_data;
        @(negedge clk);
        pmem_resp = 1'b0; pmem_rdata = $urandom;
        if (rd) exp_rdata = model_load(f3, off, mem_data);
        check("done_resp", 32'(cpu_resp), 32'd1);
        check("done_error", 32'(cpu_error), 32'd0);
        check("done_strobes_low", 32'({pmem_read, pmem_write}), 32'd0);
        check("done_rdata", cpu_rdata, exp_rdata);
      end
    end
    @(negedge clk);
    check("resp_one_cycle", 32'(cpu_resp), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_funct3 = 3'd0;
    cpu_address = 32'd0; cpu_wdata = 32'd0;
    pmem_rdata = 32'd0; pmem_resp = 1'b0;
    exp_rdata = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_strobes", 32'({pmem_read, pmem_write}), 32'd0);
    check("rst_resp_err", 32'({cpu_resp, cpu_error}), 32'd0);
    check("rst_be", 32'(pmem_byte_enable), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_address", pmem_address, 32'd0);
    check("rst_wdata", pmem_wdata, 32'd0);
    rst = 1'b0;

    // lb 0x103 with three wait cycles
    run_txn(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 3, 32'h80FF_1234);
    check("lb_example", cpu_rdata, 32'hFFFF_FF80);

    // sh 0x202
    run_txn(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 2, 32'd0);

    // lw misaligned: error, no strobe, rdata unchanged
    run_txn(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 0, 32'd0);

    // Request held high restarts in the IDLE following DONE
    @(negedge clk);
    cpu_read = 1'b1; cpu_funct3 = 3'b010; cpu_address = 32'h101;
    @(negedge clk);
    check("b2b_resp0", 32'({cpu_resp, cpu_error}), 32'd3);
    @(negedge clk);
    check("b2b_gap", 32'(cpu_resp), 32'd0);
    @(negedge clk);
    check("b2b_resp1", 32'({cpu_resp, cpu_error}), 32'd3);
    cpu_read = 1'b0;
    @(negedge clk);
    check("b2b_end", 32'(cpu_resp), 32'd0);

    // Both requests at once
    run_txn(1'b1, 1'b1, 3'b010, 32'h8, 32'd0, 0, 32'd0);

    // pmem_resp while idle is ignored
    @(negedge clk);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    check("idle_resp_ignored", 32'({cpu_resp, pmem_read, pmem_write}), 32'd0);

    // Load a known value, then time out an lhu
    run_txn(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 1, 32'h1234_5678);
    run_txn(1'b1, 1'b0, 3'b101, 32'h4, 32'd0, TIMEOUT, 32'd0);

    // Reset in the middle of a store
    @(negedge clk);
    cpu_write = 1'b1; cpu_funct3 = 3'b010; cpu_address = 32'h300; cpu_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    cpu_write = 1'b0;
    check("mid_write_strobe", 32'(pmem_write), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_write", 32'(pmem_write), 32'd0);
    check("rst_async_resp", 32'(cpu_resp), 32'd0);
    check("rst_async_addr", pmem_address, 32'd0);
    exp_rdata = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    check("late_resp_ignored", 32'({cpu_resp, pmem_write}), 32'd0);
    @(negedge clk);
    check("late_resp_quiet", 32'(cpu_resp), 32'd0);
    run_txn(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 1, 32'd0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      int         kind;
      bit         rd, wr;
      logic [2:0] f3;
      logic [31:0] a;
      kind = int'($urandom_range(0, 9));
      rd = (kind <= 5);
      wr = (kind == 0) || (kind >= 6);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[0] = 1'b0;
      run_txn(rd, wr, f3, a, $urandom, int'($urandom_range(0, 4)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles waiting for pmem_resp before abort.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cpu_read  input  1  load request from control/datapath.
REQ-005 SHALL have port cpu_write  input  1  store request.
REQ-006 SHALL have port cpu_funct3  input  3  RV32I load/store width code.
REQ-007 SHALL have port cpu_address  input  32  byte address (datapath MAR output).
REQ-008 SHALL have port cpu_wdata  input  32  unshifted store data (datapath mem_wdata).
REQ-009 SHALL have port cpu_rdata  output  32  aligned, extended load data (feeds datapath mem_rdata).
REQ-010 SHALL have port cpu_resp  output  1  one-cycle transaction-complete pulse.
REQ-011 SHALL have port cpu_error  output  1  valid with cpu_resp; misaligned, illegal funct3, both requests, or timeout.
REQ-012 SHALL have ports pmem_read / pmem_write  output  1 each  memory strobes.
REQ-013 SHALL have port pmem_address  output  32  word address, bits[1:0]=0.
REQ-014 SHALL have port pmem_wdata  output  32  lane-shifted store data.
REQ-015 SHALL have port pmem_byte_enable  output  4  active-high lane enables.
REQ-016 SHALL have ports pmem_rdata  input  32 and pmem_resp  input  1  memory return.

Function
REQ-017 SHALL implement FSM IDLE, READ, WRITE, DONE; all outputs registered.
REQ-018 IDLE: sample cpu_* each cycle; cpu_* ignored in every other state.
REQ-019 IDLE checks: both requests, illegal funct3 (load: 011/110/111; store: anything but 000/001/010), halfword with addr[0]=1, word with addr[1:0]!=0 -> DONE with error, no pmem strobe.
REQ-020 Legal load -> READ; legal store -> WRITE; pmem_read/pmem_write asserted first cycle in READ/WRITE and held until exit.
REQ-021 pmem_address = {cpu_address[31:2],2'b00}, latched in IDLE, stable through transaction.
REQ-022 Store lanes: sb byte_enable=4'b0001<<a[1:0], byte replicated to all lanes; sh 4'b0011<<a[1:0], halfword replicated; sw 4'b1111, data unchanged.
REQ-023 Loads: pmem_byte_enable=4'b1111; on pmem_resp select byte/half at a[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw pass through; result into cpu_rdata.
REQ-024 pmem_resp in READ/WRITE -> DONE, strobes drop same edge; pmem_resp in IDLE/DONE ignored.
REQ-025 8-bit wait counter cleared on entry to READ/WRITE, increments each wait cycle; reaching TIMEOUT without pmem_resp -> drop strobe, DONE with error, cpu_rdata=0.
REQ-026 DONE: cpu_resp=1 exactly one cycle, cpu_error as determined; next state IDLE unconditionally.
REQ-027 cpu_rdata holds last value until next load capture; stores and errors other than timeout leave it unchanged.
REQ-028 Minimum latency: request in IDLE at edge N, strobe N+1, pmem_resp at N+1 -> cpu_resp during cycle N+2.
REQ-029 Back-to-back: request still high in the IDLE after DONE starts a new transaction.

Reset
REQ-030 rst high SHALL immediately force IDLE, all strobes, cpu_resp, cpu_error, byte_enable to 0, cpu_rdata, pmem_address, pmem_wdata to 0, counter 0, regardless of clk.
REQ-031 Reset mid-READ/WRITE SHALL abort without cpu_resp; pmem_resp arriving after reset ignored.

Verification
REQ-032 lb addr 0x103, pmem_rdata 0x80FF_1234 after 3 waits -> pmem_address 0x100, cpu_rdata 0xFFFF_FF80, cpu_resp one cycle, error 0.
REQ-033 sh addr 0x202, wdata 0x0000_BEEF -> byte_enable 4'b1100, pmem_wdata 0xBEEF_BEEF, pmem_address 0x200, cpu_resp after pmem_resp.
REQ-034 lw addr 0x101 -> no pmem_read, cpu_resp+cpu_error 2 cycles after request, cpu_rdata unchanged.
REQ-035 lhu addr 0x4, pmem_resp never -> pmem_read high 255 cycles then low, cpu_resp+cpu_error, cpu_rdata 0.
REQ-036 rst asserted mid-WRITE between edges -> pmem_write low immediately, no cpu_resp; later pmem_resp ignored; new sw after reset completes normally.
REQ-037 cpu_read and cpu_write both high, funct3 010, addr 0x8 -> error response, no pmem strobe.
